uart_tx_framed: RTL
===================

// Module: uart_tx_framed
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed-format TX. Adds a FIFO with
//  valid/ready write handshake, optional parity (even/odd) and 1 or 2 stop bits selected at
//  run time. Sits between the APB/AES bridge datapath and the serial line. Config is latched
//  per frame; the line idles high.
// PARAMETERS
//  DATA_WIDTH  32  payload bits per frame, LSB first; legal range >=1
//  NTICKS      16  tick pulses per bit period; legal range >=2
//  FIFO_DEPTH  4   entries in the TX FIFO; must be a power of 2 and >=2
// PORTS
//  clk          in   1                 clock
//  reset_n      in   1                 async active-low reset
//  tick         in   1                 baud oversample strobe, 1 clk wide
//  wr_valid     in   1                 write request for wr_data
//  wr_ready     out  1                 FIFO not full
//  wr_data      in   DATA_WIDTH        payload
//  parity_mode  in   2                 uart_parity_e: 00 NONE, 01 EVEN, 10 ODD, 11 NONE
//  stop2        in   1                 1 = two stop bits
//  tx           out  1                 serial line
//  tx_busy      out  1                 high whenever state != IDLE
//  tx_done      out  1                 1-clk pulse at end of the last stop bit
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset values: tx=1, wr_ready=1, tx_busy=0, tx_done=0, fifo_count=0. The FIFO is flushed and
//   all counters are cleared. Reset mid-frame aborts the frame immediately; tx goes high
//   asynchronously.
//  Write: an entry is pushed when wr_valid && wr_ready. wr_ready = !full is registered-based, so
//   when the FIFO is full the write is refused even if a pop occurs in the same cycle.
//   Simultaneous push and pop leaves fifo_count unchanged.
//  FSM states (uart_tx_state_e): IDLE, START, DATA, PARITY, STOP.
//   IDLE: if the FIFO is not empty, pop into shift_reg. The same edge latches parity_mode and
//    stop2 and clears tcount; next state is START. If the FIFO is empty, stay in IDLE. No
//    fall-through: data written in cycle N is popped at the earliest in cycle N+1.
//   START: drive 0. On each tick, tcount++. On the tick with tcount==NTICKS-1, go to DATA with
//    tcount=0 and dcount=0.
//   DATA: drive shift_reg[0]. On the last tick of the bit, shift right and accumulate
//    par ^= bit. If dcount==DATA_WIDTH-1, go to PARITY when parity is enabled, else STOP.
//    Otherwise dcount++.
//   PARITY: drive par for EVEN, ~par for ODD. Lasts one bit period, then STOP.
//   STOP: drive 1. Lasts NTICKS ticks, or 2*NTICKS if stop2 was latched; stopcnt tracks the
//    bit. tx_done pulses on the final tick, and the next state is IDLE.
//  Output timing: tx is registered and changes 1 clk after the state/bit change. tx_busy is
//   combinational from the state register.
//  Back-to-back frames: the next pop happens in the IDLE cycle right after STOP, a one-clk gap.
//  Arithmetic: tcount width $clog2(NTICKS), dcount width $clog2(DATA_WIDTH) (min 1), and
//   FIFO pointers are wrapping with an extra MSB for the full/empty decision.
//  Config changes mid-frame have no effect until the next frame.
//  A tick arriving in IDLE is ignored. tick is not required to be periodic.
// STRUCTURE
//  shared_pkg: uart_parity_e, uart_tx_state_e (IDLE_T, START_T, DATA_T, PARITY_T, STOP_T),
//   PARITY_NONE/EVEN/ODD constants.
//  Sub-module: uart_tx_fifo (sync FIFO, DATA_WIDTH x FIFO_DEPTH; push/pop/full/empty/count).
//  Top: FSM plus shift register, counters, parity accumulator and registered tx.
// TESTING (DATA_WIDTH=8, NTICKS=16, FIFO_DEPTH=4, tick every clk)
//  1. Reset, write 0xA5, parity NONE, stop2=0. Line must read 0,1,0,1,0,0,1,0,1,1 with each bit
//     lasting 16 clks. tx_done pulses once, 160 ticks after START entry.
//  2. Write 0x07 with EVEN, then 0x07 with ODD. Parity bit must be 1 then 0, and the frame
//     length must be 11 bits.
//  3. stop2=1 with 0xFF. Line must stay high for 32 ticks after the MSB, and tx_done must not
//     pulse before that.
//  4. Write 5 words back-to-back while TX is idle. The first pop happens immediately, then 4
//     words fill the FIFO and wr_ready=0; the sixth write attempt is stalled. All words must
//     emerge in order with one IDLE clk between frames.
//  5. Assert reset_n low mid-DATA of 0x3C. tx must be 1 at once, fifo_count=0 and
//     tx_busy=0. After release, a new write 0x81 must be framed correctly.
//  6. Change parity_mode mid-frame and gate tick off for 100 clks. The frame must keep its
//     latched config, and the line must hold its bit while ticks are absent.

Source files
------------

// File: rtl/uart_tx_framed_pkg.sv
// Shared types for the framed UART transmitter: parity selection and FSM state encoding.
package uart_tx_framed_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_EVEN = 2'b01,
    PARITY_ODD  = 2'b10
  } uart_parity_e;

  typedef enum logic [2:0] {
    IDLE_T,
    START_T,
    DATA_T,
    PARITY_T,
    STOP_T
  } uart_tx_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_framed_fifo.sv
// Synchronous TX FIFO; wrapping pointers carry an extra MSB to separate full from empty.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // full is taken from the registered pointers, so a pop in the same cycle does not free a slot
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-fed, run-time parity and stop-bit selection latched per frame.
module uart_tx_framed
  import uart_tx_framed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NTICKS     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned TW = $clog2(NTICKS);
  localparam int unsigned DW = clog2_min1(DATA_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(NTICKS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DATA_WIDTH - 1);

  uart_tx_state_e        state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [TW-1:0]         tcount;
  logic [DW-1:0]         dcount;
  logic                  par;
  uart_parity_e          pmode_q;
  logic                  stop2_q;
  logic                  stopcnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rd;
  logic                  par_en;
  logic                  bit_end;

  assign wr_ready = !fifo_full;
  assign pop      = (state == IDLE_T) && !fifo_empty;
  assign tx_busy  = (state != IDLE_T);
  assign par_en   = (pmode_q == PARITY_EVEN) || (pmode_q == PARITY_ODD);
  assign bit_end  = tick && (tcount == T_LAST);

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE_T;
      shift_reg <= '0;
      tcount    <= '0;
      dcount    <= '0;
      par       <= 1'b0;
      pmode_q   <= PARITY_NONE;
      stop2_q   <= 1'b0;
      stopcnt   <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE_T: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_rd;
            pmode_q   <= uart_parity_e'(parity_mode);
            stop2_q   <= stop2;
            tcount    <= '0;
            par       <= 1'b0;
            stopcnt   <= 1'b0;
            state     <= START_T;
          end
        end
        START_T: begin
          tx <= 1'b0;
          if (bit_end) begin
            tcount <= '0;
            dcount <= '0;
            state  <= DATA_T;
          end else if (tick) begin
            tcount <= tcount + TW'(1);
          end
        end
        DATA_T: begin
          tx <= shift_reg[0];
          if (bit_end) begin
            tcount    <= '0;
            shift_reg <= shift_reg >> 1;
            par       <= par ^ shift_reg[0];
            if (dcount == D_LAST) state <= par_en ? PARITY_T : STOP_T;
            else                  dcount <= dcount + DW'(1);
          end else if (tick) begin
            tcount <= tcount + TW'(1);
          end
        end
        PARITY_T: begin
          tx <= (pmode_q == PARITY_ODD) ? ~par : par;
          if (bit_end) begin
            tcount <= '0;
            state  <= STOP_T;
          end else if (tick) begin
            tcount <= tcount + TW'(1);
          end
        end
        STOP_T: begin
          tx <= 1'b1;
          if (bit_end) begin
            tcount <= '0;
            // stopcnt marks the first of two stop bits when stop2 was latched
            if (stop2_q && !stopcnt) begin
              stopcnt <= 1'b1;
            end else begin
              stopcnt <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE_T;
            end
          end else if (tick) begin
            tcount <= tcount + TW'(1);
          end
        end
        default: state <= IDLE_T;
      endcase
    end
  end

endmodule
